// File: rtl/rle_pkg.sv
// Shared definitions for the run-length encoder: FSM state encoding and the
// width helpers that derive record width and maximum run length from the parameters.
package rle_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    SCAN,
    WR,
    FLUSH,
    DONE
  } rleState_e;

  // REC_W: width of one {count, symbol} record
  function automatic int recW(input int symW, input int cntW);
    return symW + cntW;
  endfunction

  // MAX_RUN: largest count a record can hold, 2^CNT_W-1
  function automatic longint unsigned maxRun(input int cntW);
    return (64'd1 << cntW) - 64'd1;
  endfunction

endpackage

// File: rtl/rle_param_if.sv
// Command/status and memory-port bundle of the encoder; the encoder uses the
// slave modport, the environment (memory plus requester) the master modport.
interface rle_param_if #(parameter int ADDR_W = 16);

  logic              start;
  logic [31:0]       message_addr;
  logic [31:0]       message_size;
  logic [31:0]       rle_addr;
  logic [31:0]       rle_size;
  logic              done;
  logic              busy;
  logic              port_A_clk;
  logic [ADDR_W-1:0] port_A_addr;
  logic              port_A_we;
  logic [31:0]       port_A_data_in;
  logic [31:0]       port_A_data_out;

  modport slave (
    input  start, message_addr, message_size, rle_addr, port_A_data_out,
    output rle_size, done, busy, port_A_clk, port_A_addr, port_A_we, port_A_data_in
  );

  modport master (
    output start, message_addr, message_size, rle_addr, port_A_data_out,
    input  rle_size, done, busy, port_A_clk, port_A_addr, port_A_we, port_A_data_in
  );

endinterface

// File: rtl/rle_packer.sv
// Packs records little-endian into a 32-bit word. word_o/full_o already include
// the record pushed this cycle, and the buffer empties on the cycle it reports full.
module rle_packer
  import rle_pkg::*;
#(
  parameter int REC_W = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              push_i,
  input  logic [REC_W-1:0]  rec_i,
  input  logic              flush_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_o
);

  localparam int RECS = WORD_W / REC_W;

  logic [WORD_W-1:0] wordBuf_q, wordBuf_d, merged;
  logic [1:0]        level_q, level_d, levelNext;

  always_comb begin
    merged    = wordBuf_q;
    levelNext = level_q;
    if (push_i) begin
      merged    = wordBuf_q | (WORD_W'(rec_i) << (REC_W * int'(level_q)));
      levelNext = level_q + 2'd1;
    end
    // A flush turns any non-empty partial word into a full one; upper bits stay zero
    full_o    = (levelNext == 2'(RECS)) || (flush_i && (levelNext != 2'd0));
    word_o    = merged;
    wordBuf_d = full_o ? '0 : merged;
    level_d   = full_o ? '0 : levelNext;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wordBuf_q <= '0;
      level_q   <= '0;
    end else begin
      wordBuf_q <= wordBuf_d;
      level_q   <= level_d;
    end
  end

endmodule

// File: rtl/rle_param.sv
// Run-length encoder: reads a frame of SYM_W-bit symbols from a single-port memory,
// emits {count, symbol} records and writes them back packed into 32-bit words.
module rle_param
  import rle_pkg::*;
#(
  parameter int SYM_W  = 8,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic       clk,
  input  logic       nreset,
  rle_param_if.slave bus
);

  localparam int REC_W = recW(SYM_W, CNT_W);
  localparam int SYMB  = SYM_W / 8;
  localparam int SYMS  = WORD_W / SYM_W;
  localparam int RECB  = REC_W / 8;
  localparam logic [CNT_W-1:0] MAX_RUN = CNT_W'(maxRun(CNT_W));

  rleState_e         state_q, state_d;
  logic [ADDR_W-1:0] srcAddr_q, srcAddr_d, dstAddr_q, dstAddr_d;
  logic [31:0]       bytesLeft_q, bytesLeft_d, recCount_q, recCount_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        symIdx_q, symIdx_d;
  logic [SYM_W-1:0]  runSym_q, runSym_d, curSym;
  logic [CNT_W-1:0]  runCnt_q, runCnt_d;
  logic              runValid_q, runValid_d;
  logic [ADDR_W-1:0] portAddr_q, portAddr_d;
  logic              portWe_q, portWe_d;
  logic [31:0]       portData_q, portData_d;

  logic              push, flush, packFull, lastSym, wordEnd, closeRun, idleLike;
  logic [REC_W-1:0]  rec;
  logic [31:0]       packWord;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^{bus.message_addr, bus.rle_addr};
  assign bus.port_A_clk = clk;

  assign idleLike = (state_q == IDLE) || (state_q == DONE);
  assign curSym   = SYM_W'(word_q >> (SYM_W * int'(symIdx_q)));
  assign lastSym  = (bytesLeft_q == 32'(SYMB));
  assign wordEnd  = (symIdx_q == 2'(SYMS - 1));
  assign closeRun = runValid_q && ((curSym != runSym_q) || (runCnt_q == MAX_RUN));
  assign rec      = {runCnt_q, runSym_q};
  assign flush    = (state_q == FLUSH);
  assign push     = ((state_q == SCAN) && closeRun) || (flush && runValid_q);

  rle_packer #(.REC_W(REC_W)) packer (
    .clk     (clk),
    .nreset  (nreset),
    .push_i  (push),
    .rec_i   (rec),
    .flush_i (flush),
    .word_o  (packWord),
    .full_o  (packFull)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    srcAddr_d   = srcAddr_q;
    dstAddr_d   = dstAddr_q;
    bytesLeft_d = bytesLeft_q;
    recCount_d  = recCount_q;
    word_d      = word_q;
    symIdx_d    = symIdx_q;
    runSym_d    = runSym_q;
    runCnt_d    = runCnt_q;
    runValid_d  = runValid_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          srcAddr_d   = bus.message_addr[ADDR_W-1:0];
          dstAddr_d   = bus.rle_addr[ADDR_W-1:0];
          bytesLeft_d = bus.message_size;
          recCount_d  = '0;
          symIdx_d    = '0;
          runSym_d    = '0;
          runCnt_d    = '0;
          runValid_d  = 1'b0;
          state_d     = (bus.message_size == 32'd0) ? FLUSH : RD_REQ;
        end
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        word_d    = bus.port_A_data_out;
        srcAddr_d = srcAddr_q + ADDR_W'(4);
        state_d   = SCAN;
      end
      SCAN: begin
        // The symbol that closes a run always opens the next one
        if (closeRun || !runValid_q) begin
          runSym_d = curSym;
          runCnt_d = CNT_W'(1);
        end else begin
          runCnt_d = runCnt_q + CNT_W'(1);
        end
        runValid_d  = 1'b1;
        bytesLeft_d = bytesLeft_q - 32'(SYMB);
        symIdx_d    = wordEnd ? 2'd0 : symIdx_q + 2'd1;
        if (packFull)     state_d = WR;
        else if (lastSym) state_d = FLUSH;
        else if (wordEnd) state_d = RD_REQ;
      end
      WR: begin
        dstAddr_d = dstAddr_q + ADDR_W'(4);
        if (bytesLeft_q == 32'd0)  state_d = runValid_q ? FLUSH : DONE;
        else if (symIdx_q == 2'd0) state_d = RD_REQ;
        else                       state_d = SCAN;
      end
      FLUSH: begin
        runValid_d = 1'b0;
        state_d    = packFull ? WR : DONE;
      end
      default: state_d = IDLE;
    endcase
    if (push) recCount_d = recCount_q + 32'd1;
  end

  // Memory-port registers are loaded on entry so each access lines up with its state
  always_comb begin
    portWe_d   = 1'b0;
    portAddr_d = portAddr_q;
    portData_d = portData_q;
    if (state_d == RD_REQ) begin
      portAddr_d = idleLike ? bus.message_addr[ADDR_W-1:0] : srcAddr_q;
    end else if (state_d == WR) begin
      portWe_d   = 1'b1;
      portAddr_d = dstAddr_q;
      portData_d = packWord;
    end
    bus.done           = (state_q == DONE);
    bus.busy           = !idleLike;
    bus.rle_size       = recCount_q * 32'(RECB);
    bus.port_A_addr    = portAddr_q;
    bus.port_A_we      = portWe_q;
    bus.port_A_data_in = portData_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      srcAddr_q   <= '0;
      dstAddr_q   <= '0;
      bytesLeft_q <= '0;
      recCount_q  <= '0;
      word_q      <= '0;
      symIdx_q    <= '0;
      runSym_q    <= '0;
      runCnt_q    <= '0;
      runValid_q  <= 1'b0;
      portAddr_q  <= '0;
      portWe_q    <= 1'b0;
      portData_q  <= '0;
    end else begin
      srcAddr_q   <= srcAddr_d;
      dstAddr_q   <= dstAddr_d;
      bytesLeft_q <= bytesLeft_d;
      recCount_q  <= recCount_d;
      word_q      <= word_d;
      symIdx_q    <= symIdx_d;
      runSym_q    <= runSym_d;
      runCnt_q    <= runCnt_d;
      runValid_q  <= runValid_d;
      portAddr_q  <= portAddr_d;
      portWe_q    <= portWe_d;
      portData_q  <= portData_d;
    end
  end

endmodule

// File: tb/tb_rle_param.sv
// Directed bench for rle_param: an 8/8 encoder and a 16/16 encoder, each on a small
// synchronous-read memory whose writes are logged and compared with hand-computed records.
module tb_rle_param;

  logic clk = 1'b0;
  logic nreset;

  always #5 clk = ~clk;

  rle_param_if #(.ADDR_W(16)) busA ();
  rle_param_if #(.ADDR_W(16)) busB ();

  rle_param #(.SYM_W(8), .CNT_W(8), .ADDR_W(16)) dutA (
    .clk    (clk),
    .nreset (nreset),
    .bus    (busA.slave)
  );

  rle_param #(.SYM_W(16), .CNT_W(16), .ADDR_W(16)) dutB (
    .clk    (clk),
    .nreset (nreset),
    .bus    (busB.slave)
  );

  logic [31:0] memA [0:255];
  logic [31:0] memB [0:15];
  logic [15:0] wrAddrA [0:63];
  logic [31:0] wrDataA [0:63];
  logic [15:0] wrAddrB [0:15];
  logic [31:0] wrDataB [0:15];
  int          wrCountA = 0;
  int          wrCountB = 0;
  int          checks = 0;
  int          errors = 0;
  int          wrBase;
  int          cycles;

  // Memories answer a read the cycle after the address; writes are only logged
  always @(posedge clk) begin
    busA.port_A_data_out <= memA[busA.port_A_addr[9:2]];
    if (busA.port_A_we) begin
      if (wrCountA < 64) begin
        wrAddrA[wrCountA] = busA.port_A_addr;
        wrDataA[wrCountA] = busA.port_A_data_in;
      end
      wrCountA++;
    end
  end

  always @(posedge clk) begin
    busB.port_A_data_out <= memB[busB.port_A_addr[5:2]];
    if (busB.port_A_we) begin
      if (wrCountB < 16) begin
        wrAddrB[wrCountB] = busB.port_A_addr;
        wrDataB[wrCountB] = busB.port_A_data_in;
      end
      wrCountB++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // poke re-asserts start (with other inputs) while encoder A is busy
  task automatic applyStimulus(input string name, input bit useB, input logic [31:0] msgAddr,
                               input logic [31:0] msgSize, input logic [31:0] rleAddr,
                               input bit poke);
    @(negedge clk);
    if (useB) begin
      busB.message_addr = msgAddr;
      busB.message_size = msgSize;
      busB.rle_addr     = rleAddr;
      busB.start        = 1'b1;
      wrBase            = wrCountB;
    end else begin
      busA.message_addr = msgAddr;
      busA.message_size = msgSize;
      busA.rle_addr     = rleAddr;
      busA.start        = 1'b1;
      wrBase            = wrCountA;
    end
    @(negedge clk);
    busA.start = 1'b0;
    busB.start = 1'b0;
    cycles     = 1;
    while (!(useB ? busB.done : busA.done) && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (poke && cycles == 3) begin
        busA.message_size = 32'd0;
        busA.rle_addr     = 32'd0;
        busA.start        = 1'b1;
      end else begin
        busA.start = 1'b0;
      end
    end
    checkOutput({name, ".done"}, useB ? busB.done : busA.done, 1);
  endtask

  initial begin
    nreset = 1'b0;
    busA.start = 1'b0; busA.message_addr = '0; busA.message_size = '0; busA.rle_addr = '0;
    busB.start = 1'b0; busB.message_addr = '0; busB.message_size = '0; busB.rle_addr = '0;
    for (int i = 0; i < 256; i++) memA[i] = 32'd0;
    for (int i = 0; i < 16; i++) memB[i] = 32'd0;
    memA[0]   = 32'h41414141;
    memA[1]   = 32'h42424141;
    memA[128] = 32'h11111111;
    memA[129] = 32'h11111111;
    memA[130] = 32'h04030201;
    memB[0]   = 32'hBEEFBEEF;

    repeat (2) @(negedge clk);
    checkOutput("rst.done", busA.done, 0);
    checkOutput("rst.busy", busA.busy, 0);
    checkOutput("rst.rleSize", busA.rle_size, 0);
    checkOutput("rst.we", busA.port_A_we, 0);
    checkOutput("rst.addr", 32'(busA.port_A_addr), 0);
    @(negedge clk);
    nreset = 1'b1;

    // Two runs across a word boundary: (6,41) then (2,42)
    applyStimulus("mixed", 1'b0, 32'h0000, 32'd8, 32'h0300, 1'b0);
    checkOutput("mixed.writes", wrCountA - wrBase, 1);
    checkOutput("mixed.addr", 32'(wrAddrA[wrBase]), 32'h0300);
    checkOutput("mixed.data", wrDataA[wrBase], 32'h02420641);
    checkOutput("mixed.rleSize", busA.rle_size, 4);
    checkOutput("mixed.busy", busA.busy, 0);

    // 300 zero bytes split at the maximum count: (255,00) and (45,00)
    applyStimulus("maxRun", 1'b0, 32'h0010, 32'd300, 32'h0340, 1'b0);
    checkOutput("maxRun.writes", wrCountA - wrBase, 1);
    checkOutput("maxRun.addr", 32'(wrAddrA[wrBase]), 32'h0340);
    checkOutput("maxRun.data", wrDataA[wrBase], 32'h2D00FF00);
    checkOutput("maxRun.rleSize", busA.rle_size, 4);

    // Odd length leaves a half-filled buffer for the flush
    applyStimulus("partial", 1'b0, 32'h0200, 32'd5, 32'h0380, 1'b0);
    checkOutput("partial.writes", wrCountA - wrBase, 1);
    checkOutput("partial.data", wrDataA[wrBase], 32'h00000511);
    checkOutput("partial.rleSize", busA.rle_size, 2);

    applyStimulus("empty", 1'b0, 32'h0000, 32'd0, 32'h03C0, 1'b0);
    checkOutput("empty.latency", 32'(cycles <= 3), 1);
    checkOutput("empty.writes", wrCountA - wrBase, 0);
    checkOutput("empty.rleSize", busA.rle_size, 0);

    // Abort a long frame with an asynchronous reset mid-scan
    @(negedge clk);
    busA.message_addr = 32'h0010; busA.message_size = 32'd300; busA.rle_addr = 32'h0340;
    busA.start = 1'b1;
    @(negedge clk);
    busA.start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("abort.busyBefore", busA.busy, 1);
    #2 nreset = 1'b0;
    #1;
    checkOutput("abort.done", busA.done, 0);
    checkOutput("abort.busy", busA.busy, 0);
    checkOutput("abort.rleSize", busA.rle_size, 0);
    checkOutput("abort.we", busA.port_A_we, 0);
    checkOutput("abort.addr", 32'(busA.port_A_addr), 0);
    checkOutput("abort.dataIn", busA.port_A_data_in, 0);
    @(negedge clk);
    nreset = 1'b1;
    wrBase = wrCountA;
    repeat (4) @(negedge clk);
    checkOutput("idle.writes", wrCountA - wrBase, 0);
    checkOutput("idle.addr", 32'(busA.port_A_addr), 0);

    applyStimulus("rerun", 1'b0, 32'h0000, 32'd8, 32'h03A0, 1'b1);
    checkOutput("rerun.writes", wrCountA - wrBase, 1);
    checkOutput("rerun.addr", 32'(wrAddrA[wrBase]), 32'h03A0);
    checkOutput("rerun.data", wrDataA[wrBase], 32'h02420641);
    checkOutput("rerun.rleSize", busA.rle_size, 4);

    applyStimulus("wide", 1'b1, 32'h0000, 32'd4, 32'h0040, 1'b0);
    checkOutput("wide.writes", wrCountB - wrBase, 1);
    checkOutput("wide.addr", 32'(wrAddrB[wrBase]), 32'h0040);
    checkOutput("wide.data", wrDataB[wrBase], 32'h0002BEEF);
    checkOutput("wide.rleSize", busB.rle_size, 4);

    // Four single-symbol runs: buffer fills mid-word, second write wraps to 0
    applyStimulus("wrap", 1'b0, 32'h0208, 32'd4, 32'hFFFC, 1'b0);
    checkOutput("wrap.writes", wrCountA - wrBase, 2);
    checkOutput("wrap.addr0", 32'(wrAddrA[wrBase]), 32'hFFFC);
    checkOutput("wrap.data0", wrDataA[wrBase], 32'h01020101);
    checkOutput("wrap.addr1", 32'(wrAddrA[wrBase + 1]), 32'h0000);
    checkOutput("wrap.data1", wrDataA[wrBase + 1], 32'h01040103);
    checkOutput("wrap.rleSize", busA.rle_size, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
